chunked_lookahead_subtractor: RTL
=================================

// Module: chunked_lookahead_subtractor
// PURPOSE
//   Multi-cycle unsigned/two's-complement subtractor, the inverse of the team's carry lookahead adder.
//   Computes A - B - BIN over W-bit slices, one slice per clock, using borrow lookahead inside each slice.
//   The borrow ripples between slices through a register.
//   Sits behind a valid/ready handshake so ALU datapaths can stall it. Area is traded for N/W cycles of latency.
// PARAMETERS
//   N  16  operand width in bits; must be a multiple of W
//   W  4   slice width processed per RUN cycle; latency = N/W cycles
// PORTS
//   clk        in   1    rising-edge clock
//   rst_n      in   1    synchronous active-low reset
//   in_valid   in   1    operands/BIN valid
//   in_ready   out  1    block can accept operands (IDLE only)
//   A          in   N    minuend
//   B          in   N    subtrahend
//   BIN        in   1    borrow-in
//   out_valid  out  1    result valid; held until out_ready
//   out_ready  in   1    consumer accepts result
//   result     out  N+1  {borrow_out, diff[N-1:0]}; borrow_out=1 iff A < B+BIN (unsigned)
//   ovf        out  1    signed overflow of A - B - BIN
// BEHAVIOUR
//   Reset (rst_n=0 at edge): state=IDLE, in_ready=1, out_valid=0, result=0, ovf=0, slice index=0.
//     Reset has priority over all other inputs, including mid-RUN and in DONE; any in-flight op is discarded.
//   FSM: IDLE -> RUN on in_valid&&in_ready. A, B and BIN are registered at this edge.
//     Input changes after acceptance have no effect.
//   RUN: k = 0..N/W-1, one slice per cycle.
//     Per bit: g=~a&b, p=~(a^b), bo[i+1]=g|(p&bo[i]), d=a^b^bo[i].
//     bo[0] of slice k is the registered borrow of slice k-1; for k=0 it is BIN.
//     diff[k*W+:W] is written into the result register at the end of cycle k.
//   RUN -> DONE after slice N/W-1. At that edge the following are loaded:
//     result[N] = final borrow
//     ovf = (A[N-1]^B[N-1]) & (diff[N-1]^A[N-1])
//     out_valid = 1
//   Latency: out_valid rises on the (N/W)th rising edge after the accepting edge (4 for defaults).
//   DONE: result and ovf are held stable while out_valid=1 && out_ready=0, with no limit on duration.
//   DONE -> IDLE on out_valid&&out_ready. out_valid drops at that edge; in_ready=1 on the following cycle.
//     There is no same-cycle accept in DONE (in_ready=0 in RUN and DONE).
//   result/ovf keep their last value in IDLE until the next completion; consumers sample only on out_valid.
//   Width rules: all slice arithmetic is W bits plus borrow; there is no sign extension.
//     ovf is meaningful for signed operands only.
//   out_ready asserted in IDLE/RUN is ignored. in_valid in RUN/DONE is ignored, and the operand is not consumed.
// TESTING (N=16, W=4)
//   Case 1: A=0x1234, B=0x0234, BIN=0.
//     -> result=0_1000, ovf=0; out_valid rises exactly 4 edges after accept.
//   Case 2: A=0x0000, B=0x0001, BIN=0 -> result=1_FFFF, ovf=0.
//     Then A=0x1000, B=0x0001, BIN=1 -> result=0_0FFE (borrow crosses all slices).
//   Case 3: A=0x8000, B=0x0001 -> result=0_7FFF, ovf=1.
//     Then A=0x7FFF, B=0xFFFF -> result=1_8000, ovf=1.
//   Case 4: hold out_ready=0 for 10 cycles after completion -> out_valid=1, result/ovf stable, in_ready=0.
//     Release out_ready -> in_ready=1 one cycle after the handshake edge.
//   Case 5: assert rst_n=0 during RUN slice 2.
//     -> next edge: IDLE, out_valid=0, result=0, ovf=0, in_ready=1; no stale completion follows.
//   Case 6: 10k random A/B/BIN with random in_valid/out_ready stalls.
//     -> every result/ovf matches the golden model {A-B-BIN}; one output per accepted input, in order.

Source files
------------

// File: rtl/chunked_lookahead_subtractor.sv
// rtl/chunked_lookahead_subtractor.sv - multi-cycle A-B-BIN subtractor, one W-bit lookahead slice per clock
module chunked_lookahead_subtractor #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         BIN,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   result,
  output logic         ovf
);

  localparam int NS = N / W;
  localparam int KW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(NS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [KW-1:0] k;
  logic [N-1:0]  a_r, b_r;
  logic          borrow_r;

  logic [W-1:0]  a_s, b_s, d_s;
  logic          slice_bout;

  // Borrow lookahead inside the current slice; borrow_r carries the slice-to-slice borrow.
  always_comb begin
    logic bo, g, p;
    a_s = a_r[k*W +: W];
    b_s = b_r[k*W +: W];
    d_s = '0;
    bo  = borrow_r;
    for (int i = 0; i < W; i++) begin
      g      = ~a_s[i] & b_s[i];
      p      = ~(a_s[i] ^ b_s[i]);
      d_s[i] = a_s[i] ^ b_s[i] ^ bo;
      bo     = g | (p & bo);
    end
    slice_bout = bo;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
      k         <= '0;
      a_r       <= '0;
      b_r       <= '0;
      borrow_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_r      <= A;
            b_r      <= B;
            borrow_r <= BIN;
            k        <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          result[k*W +: W] <= d_s;
          borrow_r         <= slice_bout;
          if (k == LAST_K) begin
            result[N] <= slice_bout;
            ovf       <= (a_r[N-1] ^ b_r[N-1]) & (d_s[W-1] ^ a_r[N-1]);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
